// File: rtl/issue_ctrl_if.sv
// Bundle between the decoder/writeback side and the dual-issue scheduler.
// Zero latency: pure wiring, no storage.
// No backpressure inside the bundle; stall/flush/pc_adv carry it back to fetch.
// Ports: decoded pair (in_valid, s1_*, s2_*), writebacks (wb1_*, wb2_*), br_taken,
//        scheduler outputs (issue1, issue2, pc_adv, stall, flush), and
//        stat_dual/stat_stall when ISSUE_STATS_EN is defined.
interface issue_ctrl_if;
    logic       in_valid;
    logic [4:0] s1_rd;
    logic [4:0] s1_rs1;
    logic [4:0] s1_rs2;
    logic       s1_we;
    logic       s1_mem;
    logic       s1_br;
    logic [4:0] s2_rd;
    logic [4:0] s2_rs1;
    logic [4:0] s2_rs2;
    logic       s2_we;
    logic       s2_mem;
    logic       wb1_en;
    logic [4:0] wb1_rd;
    logic       wb2_en;
    logic [4:0] wb2_rd;
    logic       br_taken;
    logic       issue1;
    logic       issue2;
    logic [1:0] pc_adv;
    logic       stall;
    logic       flush;
`ifdef ISSUE_STATS_EN
    logic [31:0] stat_dual;
    logic [31:0] stat_stall;
`endif

    // Decoder / writeback / branch-unit side.
    modport master (
        output in_valid, s1_rd, s1_rs1, s1_rs2, s1_we, s1_mem, s1_br,
        output s2_rd, s2_rs1, s2_rs2, s2_we, s2_mem,
        output wb1_en, wb1_rd, wb2_en, wb2_rd, br_taken,
`ifdef ISSUE_STATS_EN
        input  stat_dual, stat_stall,
`endif
        input  issue1, issue2, pc_adv, stall, flush
    );

    // Scheduler side.
    modport slave (
        input  in_valid, s1_rd, s1_rs1, s1_rs2, s1_we, s1_mem, s1_br,
        input  s2_rd, s2_rs1, s2_rs2, s2_we, s2_mem,
        input  wb1_en, wb1_rd, wb2_en, wb2_rd, br_taken,
`ifdef ISSUE_STATS_EN
        output stat_dual, stat_stall,
`endif
        output issue1, issue2, pc_adv, stall, flush
    );
endinterface

// File: rtl/issue_ctrl.sv
// Dual-issue scheduler: scoreboard + pair hazard checks + branch/flush sequencing.
// Zero-cycle decision: outputs are combinational from inputs and registered state.
// Backpressure via stall (scoreboard hazard, branch wait) and pc_adv 0/1/2; flush kills wrong path.
// Ports: clk, rst (async, active-low), io (issue_ctrl_if.slave).
// Optional: ISSUE_STATS_EN adds stat_dual/stat_stall 32-bit wrapping counters.
module issue_ctrl #(
    parameter int NREG      = 32,
    parameter int FLUSH_CYC = 2
) (
    input  logic         clk,
    input  logic         rst,
    issue_ctrl_if.slave  io
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_BR_WAIT = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic [NREG-1:0] clr_mask, set_mask, busy_eff;

    logic       issue1_c, issue2_c, stall_c, flush_c;
    logic [1:0] pc_adv_c;

    logic h1, s1_wr_nz, s2_src_ok, s2_dst_ok, pair_ok;

    // Writebacks in the current cycle already count as not busy (write-first).
    always_comb begin
        clr_mask = '0;
        if (io.wb1_en) clr_mask[io.wb1_rd] = 1'b1;
        if (io.wb2_en) clr_mask[io.wb2_rd] = 1'b1;
        busy_eff    = busy_q & ~clr_mask;
        busy_eff[0] = 1'b0;
    end

    // Hazard terms; only consumed in RUN with in_valid.
    always_comb begin
        h1 = busy_eff[io.s1_rs1] | busy_eff[io.s1_rs2] | (io.s1_we & busy_eff[io.s1_rd]);
        s1_wr_nz  = io.s1_we && (io.s1_rd != 5'd0);
        s2_src_ok = !busy_eff[io.s2_rs1] && !busy_eff[io.s2_rs2] &&
                    !(s1_wr_nz && ((io.s2_rs1 == io.s1_rd) || (io.s2_rs2 == io.s1_rd)));
        s2_dst_ok = !io.s2_we ||
                    (!busy_eff[io.s2_rd] && !(s1_wr_nz && (io.s2_rd == io.s1_rd)));
        // A branch in slot 1 must resolve before anything behind it issues.
        pair_ok   = !io.s1_br && !(io.s1_mem && io.s2_mem) && s2_src_ok && s2_dst_ok;
    end

    always_comb begin
        issue1_c = 1'b0;
        issue2_c = 1'b0;
        pc_adv_c = 2'd0;
        stall_c  = 1'b0;
        flush_c  = 1'b0;
        state_d  = state_q;
        cnt_d    = cnt_q;
        set_mask = '0;
        case (state_q)
            ST_RUN: begin
                if (io.in_valid) begin
                    if (h1) begin
                        stall_c = 1'b1;
                    end else begin
                        issue1_c = 1'b1;
                        if (io.s1_we) set_mask[io.s1_rd] = 1'b1;
                        if (pair_ok) begin
                            issue2_c = 1'b1;
                            pc_adv_c = 2'd2;
                            if (io.s2_we) set_mask[io.s2_rd] = 1'b1;
                        end else begin
                            // Slot 2 comes back next cycle as slot 1.
                            pc_adv_c = 2'd1;
                        end
                        if (io.s1_br) state_d = ST_BR_WAIT;
                    end
                end
            end
            ST_BR_WAIT: begin
                stall_c = 1'b1;
                if (io.br_taken) begin
                    // Flush already counts this cycle, so FLUSH holds FLUSH_CYC-1 more.
                    flush_c = 1'b1;
                    if (FLUSH_CYC > 1) begin
                        state_d = ST_FLUSH;
                        cnt_d   = 3'(FLUSH_CYC - 1);
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                flush_c = 1'b1;
                if (cnt_q <= 3'd1) begin
                    cnt_d   = 3'd0;
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 3'd0;
            end
        endcase
        // r0 is never tracked; set beats a same-cycle clear.
        set_mask[0] = 1'b0;
        busy_d      = (busy_q & ~clr_mask) | set_mask;
        busy_d[0]   = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Outputs are forced low while reset is asserted, independent of the pair inputs.
    assign io.issue1 = rst & issue1_c;
    assign io.issue2 = rst & issue2_c;
    assign io.pc_adv = rst ? pc_adv_c : 2'd0;
    assign io.stall  = rst & stall_c;
    assign io.flush  = rst & flush_c;

`ifdef ISSUE_STATS_EN
    logic [31:0] stat_dual_q, stat_dual_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    always_comb begin
        stat_dual_d  = stat_dual_q + {31'd0, issue2_c};
        stat_stall_d = stat_stall_q + {31'd0, (stall_c | flush_c)};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_dual_q  <= 32'd0;
            stat_stall_q <= 32'd0;
        end else begin
            stat_dual_q  <= stat_dual_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign io.stat_dual  = stat_dual_q;
    assign io.stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: reset, dual issue, hazards, scoreboard, branch/flush.
// Outputs packed as {issue1, issue2, pc_adv[1:0], stall, flush} and compared to hand values.
// Inputs change 1ns after the rising edge; outputs are sampled 2ns later.
module tb_issue_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [5:0] want;

    issue_ctrl_if io();

    issue_ctrl #(.NREG(32), .FLUSH_CYC(2)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    wire [5:0] outs = {io.issue1, io.issue2, io.pc_adv, io.stall, io.flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        io.in_valid = 1'b0;
        io.s1_rd = 5'd0; io.s1_rs1 = 5'd0; io.s1_rs2 = 5'd0;
        io.s1_we = 1'b0; io.s1_mem = 1'b0; io.s1_br = 1'b0;
        io.s2_rd = 5'd0; io.s2_rs1 = 5'd0; io.s2_rs2 = 5'd0;
        io.s2_we = 1'b0; io.s2_mem = 1'b0;
        io.wb1_en = 1'b0; io.wb1_rd = 5'd0;
        io.wb2_en = 1'b0; io.wb2_rd = 5'd0;
        io.br_taken = 1'b0;
    endtask

    task automatic pair(input logic [4:0] a_rd, input logic [4:0] a_rs1, input logic [4:0] a_rs2,
                        input logic a_we, input logic a_mem, input logic a_br,
                        input logic [4:0] b_rd, input logic [4:0] b_rs1, input logic [4:0] b_rs2,
                        input logic b_we, input logic b_mem);
        io.in_valid = 1'b1;
        io.s1_rd = a_rd; io.s1_rs1 = a_rs1; io.s1_rs2 = a_rs2;
        io.s1_we = a_we; io.s1_mem = a_mem; io.s1_br = a_br;
        io.s2_rd = b_rd; io.s2_rs1 = b_rs1; io.s2_rs2 = b_rs2;
        io.s2_we = b_we; io.s2_mem = b_mem;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        pair(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 5'd4, 5'd5, 5'd6, 1'b1, 1'b0);
        #2;
        want = 6'b0_0_00_0_0; checks++;
        if (outs !== want) begin errors++; $display("FAIL reset_outs got=%b want=%b", outs, want); end
        tick();
        checks++;
        if (outs !== want) begin errors++; $display("FAIL reset_held got=%b want=%b", outs, want); end
        idle();
        rst = 1'b1;
        #2;
        checks++;
        if (outs !== want) begin errors++; $display("FAIL reset_idle got=%b want=%b", outs, want); end
        tick();
    endtask

    task automatic test_dual();
        pair(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 5'd4, 5'd5, 5'd6, 1'b1, 1'b0);
        #2;
        want = 6'b1_1_10_0_0; checks++;
        if (outs !== want) begin errors++; $display("FAIL dual_issue got=%b want=%b", outs, want); end
        tick();
        pair(5'd10, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #2;
        want = 6'b0_0_00_1_0; checks++;
        if (outs !== want) begin errors++; $display("FAIL dual_r1_busy got=%b want=%b", outs, want); end
        pair(5'd10, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd11, 5'd4, 5'd0, 1'b0, 1'b0);
        #1;
        want = 6'b1_0_01_0_0; checks++;
        if (outs !== want) begin errors++; $display("FAIL dual_r4_busy got=%b want=%b", outs, want); end
        tick();
        idle();
        io.wb1_en = 1'b1; io.wb1_rd = 5'd1;
        io.wb2_en = 1'b1; io.wb2_rd = 5'd4;
        tick();
        idle();
        pair(5'd10, 5'd1, 5'd4, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #2;
        want = 6'b1_1_10_0_0; checks++;
        if (outs !== want) begin errors++; $display("FAIL dual_cleared got=%b want=%b", outs, want); end
        tick();
        idle();
    endtask

    task automatic test_intra_pair();
        pair(5'd7, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 5'd8, 5'd7, 5'd2, 1'b1, 1'b0);
        #2;
        want = 6'b1_0_01_0_0; checks++;
        if (outs !== want) begin errors++; $display("FAIL raw_pair got=%b want=%b", outs, want); end
        tick();
        idle();
        io.wb1_en = 1'b1; io.wb1_rd = 5'd7;
        tick();
        idle();
        pair(5'd6, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd6, 5'd0, 5'd0, 1'b1, 1'b0);
        #2;
        want = 6'b1_0_01_0_0; checks++;
        if (outs !== want) begin errors++; $display("FAIL waw_pair got=%b want=%b", outs, want); end
        tick();
        idle();
        io.wb2_en = 1'b1; io.wb2_rd = 5'd6;
        tick();
        idle();
    endtask

    task automatic test_scoreboard();
        pair(5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #2;
        want = 6'b1_1_10_0_0; checks++;
        if (outs !== want) begin errors++; $display("FAIL sb_set_r9 got=%b want=%b", outs, want); end
        tick();
        pair(5'd11, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #2;
        want = 6'b0_0_00_1_0; checks++;
        if (outs !== want) begin errors++; $display("FAIL sb_stall1 got=%b want=%b", outs, want); end
        tick();
        #2;
        checks++;
        if (outs !== want) begin errors++; $display("FAIL sb_stall2 got=%b want=%b", outs, want); end
        tick();
        io.wb1_en = 1'b1; io.wb1_rd = 5'd9;
        #2;
        want = 6'b1_1_10_0_0; checks++;
        if (outs !== want) begin errors++; $display("FAIL sb_write_first got=%b want=%b", outs, want); end
        tick();
        // r12 set while a writeback to r12 lands: the set must survive.
        pair(5'd12, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        io.wb1_en = 1'b1; io.wb1_rd = 5'd12;
        io.wb2_en = 1'b1; io.wb2_rd = 5'd11;
        tick();
        io.wb1_en = 1'b0; io.wb2_en = 1'b0;
        pair(5'd13, 5'd12, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #2;
        want = 6'b0_0_00_1_0; checks++;
        if (outs !== want) begin errors++; $display("FAIL sb_set_wins got=%b want=%b", outs, want); end
        pair(5'd12, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #1;
        checks++;
        if (outs !== want) begin errors++; $display("FAIL sb_waw_s1 got=%b want=%b", outs, want); end
        pair(5'd13, 5'd11, 5'd9, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #1;
        want = 6'b1_1_10_0_0; checks++;
        if (outs !== want) begin errors++; $display("FAIL sb_cleared got=%b want=%b", outs, want); end
        tick();
        idle();
        io.wb1_en = 1'b1; io.wb1_rd = 5'd12;
        tick();
        idle();
    endtask

    task automatic test_mem_r0();
        pair(5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 5'd3, 5'd4, 5'd0, 1'b1, 1'b1);
        #2;
        want = 6'b1_0_01_0_0; checks++;
        if (outs !== want) begin errors++; $display("FAIL two_mem got=%b want=%b", outs, want); end
        tick();
        idle();
        io.wb1_en = 1'b1; io.wb1_rd = 5'd1;
        tick();
        idle();
        pair(5'd0, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0);
        #2;
        want = 6'b1_1_10_0_0; checks++;
        if (outs !== want) begin errors++; $display("FAIL r0_pair got=%b want=%b", outs, want); end
        tick();
        pair(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0);
        #2;
        want = 6'b1_0_01_0_0; checks++;
        if (outs !== want) begin errors++; $display("FAIL s2_busy_src got=%b want=%b", outs, want); end
        tick();
        idle();
        io.wb2_en = 1'b1; io.wb2_rd = 5'd5;
        #2;
        want = 6'b0_0_00_0_0; checks++;
        if (outs !== want) begin errors++; $display("FAIL no_valid got=%b want=%b", outs, want); end
        tick();
        idle();
    endtask

    task automatic test_branch();
        pair(5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0);
        #2;
        want = 6'b1_0_01_0_0; checks++;
        if (outs !== want) begin errors++; $display("FAIL br_issue got=%b want=%b", outs, want); end
        tick();
        io.br_taken = 1'b1;
        #2;
        want = 6'b0_0_00_1_1; checks++;
        if (outs !== want) begin errors++; $display("FAIL br_wait_taken got=%b want=%b", outs, want); end
        tick();
        #2;
        want = 6'b0_0_00_0_1; checks++;
        if (outs !== want) begin errors++; $display("FAIL br_flush got=%b want=%b", outs, want); end
        tick();
        io.br_taken = 1'b0;
        pair(5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 5'd3, 5'd4, 1'b0, 1'b0);
        #2;
        want = 6'b1_1_10_0_0; checks++;
        if (outs !== want) begin errors++; $display("FAIL br_back_run got=%b want=%b", outs, want); end
        tick();
        pair(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #2;
        want = 6'b1_0_01_0_0; checks++;
        if (outs !== want) begin errors++; $display("FAIL br2_issue got=%b want=%b", outs, want); end
        tick();
        #2;
        want = 6'b0_0_00_1_0; checks++;
        if (outs !== want) begin errors++; $display("FAIL br_wait_not_taken got=%b want=%b", outs, want); end
        tick();
        pair(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #2;
        want = 6'b1_1_10_0_0; checks++;
        if (outs !== want) begin errors++; $display("FAIL br_nt_run got=%b want=%b", outs, want); end
        tick();
        idle();
    endtask

    task automatic test_reset_flush();
        pair(5'd20, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        pair(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        io.br_taken = 1'b1;
        tick();
        io.br_taken = 1'b0;
        #1;
        want = 6'b0_0_00_0_1; checks++;
        if (outs !== want) begin errors++; $display("FAIL rf_in_flush got=%b want=%b", outs, want); end
        rst = 1'b0;
        #1;
        want = 6'b0_0_00_0_0; checks++;
        if (outs !== want) begin errors++; $display("FAIL rf_outs_zero got=%b want=%b", outs, want); end
`ifdef ISSUE_STATS_EN
        checks++;
        if (io.stat_dual !== 32'd0) begin errors++; $display("FAIL rf_stat_dual got=%0d want=0", io.stat_dual); end
        checks++;
        if (io.stat_stall !== 32'd0) begin errors++; $display("FAIL rf_stat_stall got=%0d want=0", io.stat_stall); end
`endif
        tick();
        rst = 1'b1;
        pair(5'd21, 5'd20, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #2;
        want = 6'b1_1_10_0_0; checks++;
        if (outs !== want) begin errors++; $display("FAIL rf_post_reset got=%b want=%b", outs, want); end
        tick();
        idle();
`ifdef ISSUE_STATS_EN
        #1;
        checks++;
        if (io.stat_dual !== 32'd1) begin errors++; $display("FAIL rf_stat_dual_inc got=%0d want=1", io.stat_dual); end
        checks++;
        if (io.stat_stall !== 32'd0) begin errors++; $display("FAIL rf_stat_stall_after got=%0d want=0", io.stat_stall); end
`endif
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_dual();
        test_intra_pair();
        test_scoreboard();
        test_mem_r0();
        test_branch();
        test_reset_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
